rf_vec_xfer_ctrl: RTL and testbench
===================================

// Module: rf_vec_xfer_ctrl
// PURPOSE
//  Sequencer that moves data between the 4x8-bit scalar register file (RF) and the
//  4x32-bit vector register file (VRF). PACK gathers r0..r3 into one vector register;
//  UNPACK scatters one vector register into r0..r3. Drives the RF/VRF read/write ports
//  over several cycles. Top level muxes its port outputs onto RF/VRF while busy=1.
// PARAMETERS
//  BYTE_W  8  scalar width; fixed to 8, no other value is supported
//  LANES   4  bytes per vector / scalar regs touched; fixed to 4
// PORTS
//  clock       in   1   rising-edge clock
//  reset       in   1   synchronous, active-high
//  start       in   1   request; sampled only in IDLE
//  op          in   1   0=PACK (RF->VRF), 1=UNPACK (VRF->RF); latched on accept
//  vreg        in   2   vector reg index (PACK dest / UNPACK src); latched on accept
//  busy        out  1   high in every state except IDLE
//  done        out  1   one-cycle pulse in DONE state
//  rf_reg1     out  2   RF read select port 1
//  rf_reg2     out  2   RF read select port 2
//  rf_data1    in   8   RF read data port 1 (combinational from rf_reg1)
//  rf_data2    in   8   RF read data port 2 (combinational from rf_reg2)
//  rf_regw     out  2   RF write select
//  rf_dataw    out  8   RF write data
//  rf_write    out  1   RF write enable
//  vrf_vreg1   out  2   VRF read select
//  vrf_vdata1  in   32  VRF read data (combinational from vrf_vreg1)
//  vrf_vregw   out  2   VRF write select
//  vrf_vdataw  out  32  VRF write data
//  vrf_write   out  1   VRF write enable
// BEHAVIOUR
//  Reset: state=IDLE, buf[31:0]=0, lane=0, op/vreg latches=0; all outputs 0.
//  rf_write and vrf_write are gated with ~reset: no write is issued in a reset cycle.
//  Unused selects/data outputs are driven 0 in every state that does not use them.
//  States / transitions (one per clock):
//   IDLE   : start=1 -> latch op,vreg; op=0 -> P_RD01, op=1 -> U_RD; else stay.
//   P_RD01 : rf_reg1=0, rf_reg2=1; buf[7:0]<=rf_data1, buf[15:8]<=rf_data2 -> P_RD23
//   P_RD23 : rf_reg1=2, rf_reg2=3; buf[23:16]<=rf_data1, buf[31:24]<=rf_data2 -> P_WR
//   P_WR   : vrf_vregw=vreg_l, vrf_vdataw=buf, vrf_write=1 -> DONE
//   U_RD   : vrf_vreg1=vreg_l; buf<=vrf_vdata1; lane<=0 -> U_WR
//   U_WR   : rf_regw=lane, rf_dataw=buf[8*lane+:8], rf_write=1; lane<=lane+1;
//            lane==3 -> DONE, else stay
//   DONE   : done=1, busy=1 -> IDLE
//  Latency (start accepted at edge E0): PACK vrf_write in cycle E0+3, done E0+4;
//   UNPACK rf_write cycles E0+2..E0+5 (r0..r3), done E0+6. Lane order r0 = bits[7:0].
//  start while busy (including DONE) is ignored; op/vreg changes mid-op have no effect.
//  Exactly one VRF write per PACK, exactly four RF writes per UNPACK, never both.
//  reset mid-operation: return to IDLE at that edge, buf/lane cleared, no remaining
//   writes issued, no done pulse; RF/VRF contents already written stay as written.
//  lane is 2 bits and wraps 3->0 only on the DONE transition; it never exceeds 3.
// TESTING
//  1 reset held 2 cycles -> all outputs 0, busy=0, done=0; start while reset=1 ignored.
//  2 RF r0..r3=11,22,33,44 (hex), start op=0 vreg=2 -> E0+3: vrf_write=1, vregw=2,
//    vdataw=0x44332211; E0+4 done=1; E0+5 busy=0.
//  3 VRF v1=0xDEADBEEF, start op=1 vreg=1 -> rf_write E0+2..E0+5 writing r0=EF,
//    r1=BE, r2=AD, r3=DE; done at E0+6; vrf_write never asserted.
//  4 start op=1 vreg=3 pulsed during PACK (states P_RD23 and DONE) -> ignored;
//    single vrf_write to vreg 2, no rf_write.
//  5 reset asserted in P_RD23 cycle -> no vrf_write, no done; next start op=0 runs
//    normally with fresh buf contents.
//  6 back-to-back: start held high continuously -> second op accepted in the IDLE
//    cycle after DONE (PACK period = 5 cycles); verify no overlap of write strobes.

Source files
------------

// File: rtl/rf_vec_xfer_ctrl.sv
// Sequencer moving data between the 4x8 scalar register file and the 4x32 vector register file.
// PACK gathers r0..r3 into one vector register; UNPACK scatters one vector register to r0..r3.
module rf_vec_xfer_ctrl #(
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned LANES  = 4
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic                      op_i,
    input  logic [1:0]                vreg_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [1:0]                rf_reg1_o,
    output logic [1:0]                rf_reg2_o,
    input  logic [BYTE_W-1:0]         rf_data1_i,
    input  logic [BYTE_W-1:0]         rf_data2_i,
    output logic [1:0]                rf_regw_o,
    output logic [BYTE_W-1:0]         rf_dataw_o,
    output logic                      rf_write_o,
    output logic [1:0]                vrf_vreg1_o,
    input  logic [BYTE_W*LANES-1:0]   vrf_vdata1_i,
    output logic [1:0]                vrf_vregw_o,
    output logic [BYTE_W*LANES-1:0]   vrf_vdataw_o,
    output logic                      vrf_write_o
);

    typedef enum logic [2:0] {
        StIdle,
        StPRd01,
        StPRd23,
        StPWr,
        StURd,
        StUWr,
        StDone
    } state_e;

    state_e                    state_q;
    logic [BYTE_W*LANES-1:0]   data_q;
    logic [1:0]                lane_q;
    logic [1:0]                vreg_q;
    logic [1:0]                lane_inc;

    logic                      busy_q, done_q;
    logic [1:0]                rf_reg1_q, rf_reg2_q, rf_regw_q;
    logic [BYTE_W-1:0]         rf_dataw_q;
    logic                      rf_write_q;
    logic [1:0]                vrf_vreg1_q, vrf_vregw_q;
    logic [BYTE_W*LANES-1:0]   vrf_vdataw_q;
    logic                      vrf_write_q;

    assign lane_inc = lane_q + 2'd1;

    // Outputs are registered as a function of the state being entered, so they are
    // valid for the whole cycle spent in that state.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            data_q       <= '0;
            lane_q       <= '0;
            vreg_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rf_reg1_q    <= '0;
            rf_reg2_q    <= '0;
            rf_regw_q    <= '0;
            rf_dataw_q   <= '0;
            rf_write_q   <= 1'b0;
            vrf_vreg1_q  <= '0;
            vrf_vregw_q  <= '0;
            vrf_vdataw_q <= '0;
            vrf_write_q  <= 1'b0;
        end else begin
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            rf_reg1_q    <= '0;
            rf_reg2_q    <= '0;
            rf_regw_q    <= '0;
            rf_dataw_q   <= '0;
            rf_write_q   <= 1'b0;
            vrf_vreg1_q  <= '0;
            vrf_vregw_q  <= '0;
            vrf_vdataw_q <= '0;
            vrf_write_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        vreg_q <= vreg_i;
                        if (!op_i) begin
                            state_q   <= StPRd01;
                            rf_reg1_q <= 2'd0;
                            rf_reg2_q <= 2'd1;
                        end else begin
                            state_q     <= StURd;
                            vrf_vreg1_q <= vreg_i;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                StPRd01: begin
                    data_q[2*BYTE_W-1:0] <= {rf_data2_i, rf_data1_i};
                    state_q              <= StPRd23;
                    rf_reg1_q            <= 2'd2;
                    rf_reg2_q            <= 2'd3;
                end
                StPRd23: begin
                    data_q[4*BYTE_W-1:2*BYTE_W] <= {rf_data2_i, rf_data1_i};
                    state_q      <= StPWr;
                    vrf_vregw_q  <= vreg_q;
                    vrf_vdataw_q <= {rf_data2_i, rf_data1_i, data_q[2*BYTE_W-1:0]};
                    vrf_write_q  <= 1'b1;
                end
                StPWr: begin
                    state_q <= StDone;
                    done_q  <= 1'b1;
                end
                StURd: begin
                    data_q     <= vrf_vdata1_i;
                    lane_q     <= 2'd0;
                    state_q    <= StUWr;
                    rf_regw_q  <= 2'd0;
                    rf_dataw_q <= vrf_vdata1_i[BYTE_W-1:0];
                    rf_write_q <= 1'b1;
                end
                StUWr: begin
                    lane_q <= lane_inc;
                    if (lane_q == 2'd3) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else begin
                        rf_regw_q  <= lane_inc;
                        rf_dataw_q <= data_q[{lane_inc, 3'b000} +: BYTE_W];
                        rf_write_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign rf_reg1_o    = rf_reg1_q;
    assign rf_reg2_o    = rf_reg2_q;
    assign rf_regw_o    = rf_regw_q;
    assign rf_dataw_o   = rf_dataw_q;
    assign vrf_vreg1_o  = vrf_vreg1_q;
    assign vrf_vregw_o  = vrf_vregw_q;
    assign vrf_vdataw_o = vrf_vdataw_q;
    // Write strobes are suppressed in any cycle where reset is asserted.
    assign rf_write_o   = rf_write_q & ~reset_i;
    assign vrf_write_o  = vrf_write_q & ~reset_i;

endmodule

// File: tb/tb_rf_vec_xfer_ctrl.sv
// Directed self-checking bench for rf_vec_xfer_ctrl with behavioural RF/VRF models.
module tb_rf_vec_xfer_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, op;
    logic [1:0]  vreg;
    logic        busy, done;
    logic [1:0]  rf_reg1, rf_reg2, rf_regw, vrf_vreg1, vrf_vregw;
    logic [7:0]  rf_data1, rf_data2, rf_dataw;
    logic        rf_write, vrf_write;
    logic [31:0] vrf_vdata1, vrf_vdataw;

    logic [7:0]  rf_mem  [4];
    logic [31:0] vrf_mem [4];

    int vecs = 0;
    int errs = 0;
    int rf_wr_cnt = 0;
    int vrf_wr_cnt = 0;
    int overlap_cnt = 0;
    int rf_base, vrf_base;

    always #5 clk = ~clk;

    assign rf_data1   = rf_mem[rf_reg1];
    assign rf_data2   = rf_mem[rf_reg2];
    assign vrf_vdata1 = vrf_mem[vrf_vreg1];

    always @(posedge clk) begin
        if (rf_write) begin
            rf_mem[rf_regw] <= rf_dataw;
            rf_wr_cnt       <= rf_wr_cnt + 1;
        end
        if (vrf_write) begin
            vrf_mem[vrf_vregw] <= vrf_vdataw;
            vrf_wr_cnt         <= vrf_wr_cnt + 1;
        end
        if (rf_write && vrf_write) overlap_cnt <= overlap_cnt + 1;
    end

    rf_vec_xfer_ctrl dut (
        .clock_i      (clk),
        .reset_i      (reset),
        .start_i      (start),
        .op_i         (op),
        .vreg_i       (vreg),
        .busy_o       (busy),
        .done_o       (done),
        .rf_reg1_o    (rf_reg1),
        .rf_reg2_o    (rf_reg2),
        .rf_data1_i   (rf_data1),
        .rf_data2_i   (rf_data2),
        .rf_regw_o    (rf_regw),
        .rf_dataw_o   (rf_dataw),
        .rf_write_o   (rf_write),
        .vrf_vreg1_o  (vrf_vreg1),
        .vrf_vdata1_i (vrf_vdata1),
        .vrf_vregw_o  (vrf_vregw),
        .vrf_vdataw_o (vrf_vdataw),
        .vrf_write_o  (vrf_write)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_rf(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] d);
        rf_mem[0] = a; rf_mem[1] = b; rf_mem[2] = c; rf_mem[3] = d;
    endtask

    initial begin
        set_rf(8'h11, 8'h22, 8'h33, 8'h44);
        vrf_mem[0] = '0; vrf_mem[1] = 32'hDEADBEEF; vrf_mem[2] = '0; vrf_mem[3] = '0;

        // 1: reset held two cycles with start high
        reset = 1'b1; start = 1'b1; op = 1'b0; vreg = 2'd0;
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_strobes", {30'd0, rf_write, vrf_write}, 32'd0);
        chk("rst_sel", {24'd0, rf_reg1, rf_reg2, rf_regw, vrf_vregw}, 32'd0);
        chk("rst_data", vrf_vdataw | {24'd0, rf_dataw} | {30'd0, vrf_vreg1}, 32'd0);
        reset = 1'b0; start = 1'b0;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // 2: PACK r0..r3 into v2
        vrf_base = vrf_wr_cnt; rf_base = rf_wr_cnt;
        start = 1'b1; op = 1'b0; vreg = 2'd2;
        tick(); start = 1'b0;
        chk("p_rd01_sel", {28'd0, rf_reg1, rf_reg2}, 32'h1);
        chk("p_rd01_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("p_rd23_sel", {28'd0, rf_reg1, rf_reg2}, 32'hB);
        chk("p_rd23_nowr", {31'd0, vrf_write}, 32'd0);
        tick();
        chk("p_wr_we", {31'd0, vrf_write}, 32'd1);
        chk("p_wr_vregw", {30'd0, vrf_vregw}, 32'd2);
        chk("p_wr_data", vrf_vdataw, 32'h44332211);
        chk("p_wr_done", {31'd0, done}, 32'd0);
        tick();
        chk("p_done", {30'd0, busy, done}, 32'd3);
        chk("p_done_we", {31'd0, vrf_write}, 32'd0);
        tick();
        chk("p_end_busy", {30'd0, busy, done}, 32'd0);
        chk("p_vrf2", vrf_mem[2], 32'h44332211);
        chk("p_cnt", {vrf_wr_cnt - vrf_base, rf_wr_cnt - rf_base}, {32'd1, 32'd0});

        // 3: UNPACK v1 into r0..r3
        vrf_base = vrf_wr_cnt; rf_base = rf_wr_cnt;
        start = 1'b1; op = 1'b1; vreg = 2'd1;
        tick(); start = 1'b0;
        chk("u_rd_sel", {30'd0, vrf_vreg1}, 32'd1);
        chk("u_rd_nowr", {31'd0, rf_write}, 32'd0);
        tick();
        chk("u_wr0", {21'd0, rf_write, rf_regw, rf_dataw}, {21'd0, 1'b1, 2'd0, 8'hEF});
        tick();
        chk("u_wr1", {21'd0, rf_write, rf_regw, rf_dataw}, {21'd0, 1'b1, 2'd1, 8'hBE});
        tick();
        chk("u_wr2", {21'd0, rf_write, rf_regw, rf_dataw}, {21'd0, 1'b1, 2'd2, 8'hAD});
        tick();
        chk("u_wr3", {21'd0, rf_write, rf_regw, rf_dataw}, {21'd0, 1'b1, 2'd3, 8'hDE});
        chk("u_wr3_done", {31'd0, done}, 32'd0);
        tick();
        chk("u_done", {29'd0, busy, done, rf_write}, 32'd6);
        tick();
        chk("u_end_busy", {31'd0, busy}, 32'd0);
        chk("u_rf", {rf_mem[3], rf_mem[2], rf_mem[1], rf_mem[0]}, 32'hDEADBEEF);
        chk("u_cnt", {vrf_wr_cnt - vrf_base, rf_wr_cnt - rf_base}, {32'd0, 32'd4});

        // 4: start pulses during PACK are ignored
        set_rf(8'h55, 8'h66, 8'h77, 8'h88);
        vrf_base = vrf_wr_cnt; rf_base = rf_wr_cnt;
        start = 1'b1; op = 1'b0; vreg = 2'd2;
        tick(); start = 1'b0;
        tick(); start = 1'b1; op = 1'b1; vreg = 2'd3;
        tick(); start = 1'b0;
        chk("ign_vregw", {29'd0, vrf_write, vrf_vregw}, {29'd0, 1'b1, 2'd2});
        tick();
        chk("ign_done", {31'd0, done}, 32'd1);
        start = 1'b1; op = 1'b1; vreg = 2'd3;
        tick(); start = 1'b0;
        chk("ign_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("ign_stay_idle", {31'd0, busy}, 32'd0);
        chk("ign_vrf2", vrf_mem[2], 32'h88776655);
        chk("ign_vrf3", vrf_mem[3], 32'd0);
        chk("ign_cnt", {vrf_wr_cnt - vrf_base, rf_wr_cnt - rf_base}, {32'd1, 32'd0});

        // 5: reset in P_RD23 aborts, then a fresh PACK runs normally
        set_rf(8'h01, 8'h02, 8'h03, 8'h04);
        vrf_base = vrf_wr_cnt; rf_base = rf_wr_cnt;
        start = 1'b1; op = 1'b0; vreg = 2'd0;
        tick(); start = 1'b0;
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        chk("abort_state", {29'd0, busy, done, vrf_write}, 32'd0);
        tick();
        chk("abort_idle", {30'd0, busy, done}, 32'd0);
        chk("abort_cnt", vrf_wr_cnt - vrf_base, 32'd0);
        chk("abort_vrf0", vrf_mem[0], 32'd0);
        set_rf(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        start = 1'b1; op = 1'b0; vreg = 2'd0;
        tick(); start = 1'b0;
        tick(); tick();
        chk("fresh_wr", vrf_vdataw, 32'hD4C3B2A1);
        tick(); tick();
        chk("fresh_vrf0", vrf_mem[0], 32'hD4C3B2A1);

        // reset during an UNPACK write cycle must suppress that write
        rf_mem[0] = 8'h00;
        rf_base = rf_wr_cnt;
        start = 1'b1; op = 1'b1; vreg = 2'd1;
        tick(); start = 1'b0;
        tick(); reset = 1'b1; #1;
        chk("gate_rf_write", {31'd0, rf_write}, 32'd0);
        tick(); reset = 1'b0;
        tick();
        chk("gate_rf0", {24'd0, rf_mem[0]}, 32'd0);
        chk("gate_cnt", rf_wr_cnt - rf_base, 32'd0);
        chk("gate_idle", {30'd0, busy, done}, 32'd0);

        // 6: start held high, back-to-back PACKs
        set_rf(8'h11, 8'h22, 8'h33, 8'h44);
        vrf_base = vrf_wr_cnt; rf_base = rf_wr_cnt;
        start = 1'b1; op = 1'b0; vreg = 2'd3;
        tick();
        tick();
        tick();
        chk("b2b_wr1", {31'd0, vrf_write}, 32'd1);
        tick();
        chk("b2b_done1", {31'd0, done}, 32'd1);
        tick();
        chk("b2b_idle", {30'd0, busy, vrf_write}, 32'd0);
        tick();
        chk("b2b_accept2", {29'd0, busy, rf_reg2}, 32'd5);
        tick(); start = 1'b0;
        tick();
        chk("b2b_wr2", {31'd0, vrf_write}, 32'd1);
        tick();
        chk("b2b_done2", {31'd0, done}, 32'd1);
        tick();
        chk("b2b_end", {31'd0, busy}, 32'd0);
        chk("b2b_cnt", {vrf_wr_cnt - vrf_base, rf_wr_cnt - rf_base}, {32'd2, 32'd0});
        chk("b2b_vrf3", vrf_mem[3], 32'h44332211);
        chk("no_overlap", overlap_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
